lfsr_seq_checker: RTL and testbench

- Receive-side checker for the 32-bit XNOR LFSR random-number stream used on the board. Polynomial taps are 32, 22, 2, 1.
- Each input sample is the generator's low byte, which shifts one bit per valid sample.
- The block self-synchronises to the incoming stream, then predicts every following sample and compares it with what arrives.
- It reports lock status, per-sample error pulses and a saturating error count. It sits at the far end of a link or loopback for BIST and link-integrity testing.

---
 rtl/lfsr_seq_checker.sv | 104 ++++++++++
 tb/tb_lfsr_seq_checker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the 32-bit XNOR LFSR stream (taps 32,22,2,1).
// Self-synchronises on 32 continuous samples, then predicts and flags mismatches.
module lfsr_seq_checker #(
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned FILL_W = 6;
  localparam int unsigned MISS_W = 4;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            state;
  logic [31:0]       s;
  logic [6:0]        p;
  logic [FILL_W-1:0] fill;
  logic [MISS_W-1:0] miss;

  logic              fb;
  logic [7:0]        pred;
  logic              brk;
  logic [31:0]       s_hunt;
  logic [FILL_W-1:0] fill_hunt;
  logic [MISS_W-1:0] miss_inc;
  logic              mismatch;

  // Prediction and hunt-path next values
  always_comb begin
    fb        = ~(s[31] ^ s[21] ^ s[1] ^ s[0]);
    pred      = {s[6:0], fb};
    brk       = (fill != '0) && (din[7:1] != p);
    s_hunt    = brk ? {31'b0, din[0]} : {s[30:0], din[0]};
    fill_hunt = brk ? FILL_W'(1) : fill + FILL_W'(1);
    mismatch  = (din != pred);
    miss_inc  = miss + MISS_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      s         <= '0;
      p         <= '0;
      fill      <= '0;
      miss      <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            s <= s_hunt;
            p <= din[6:0];
            if (fill_hunt == FILL_W'(32)) begin
              fill <= '0;
              // All-ones is the XNOR lock-up state; never lock onto it
              if (s_hunt != '1) begin
                state  <= LOCK;
                locked <= 1'b1;
                miss   <= '0;
              end
            end else begin
              fill <= fill_hunt;
            end
          end
          LOCK: begin
            // Advance from the prediction so one bad sample gives one error
            s <= {s[30:0], fb};
            if (mismatch) begin
              err <= 1'b1;
              if (err_count != '1) err_count <= err_count + CNT_W'(1);
              if (miss_inc == MISS_W'(LOSS_THRESH)) begin
                state  <= HUNT;
                locked <= 1'b0;
                fill   <= '0;
                miss   <= '0;
              end else begin
                miss <= miss_inc;
              end
            end else begin
              miss <= '0;
            end
          end
        endcase
      end
      // Clear overrides a same-edge increment
      if (clr_cnt) err_count <= '0;
    end
  end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed/randomised bench for lfsr_seq_checker against a queue-based reference model.
module tb_lfsr_seq_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic        din_valid;
  logic        clr_cnt;
  logic        locked, err;
  logic [15:0] err_count;
  logic        locked4, err4;
  logic [3:0]  err_count4;

  always #5 clk = ~clk;

  lfsr_seq_checker #(.LOSS_THRESH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
    .locked(locked), .err(err), .err_count(err_count)
  );

  lfsr_seq_checker #(.LOSS_THRESH(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
    .locked(locked4), .err(err4), .err_count(err_count4)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  bit          m_locked;
  bit          hq[$];
  logic [7:0]  m_prev;
  logic [31:0] m_pred;
  int          m_miss;
  int          m_cnt;
  bit          exp_err;
  logic [31:0] gen;

  function automatic logic [31:0] lfsr_next(input logic [31:0] g);
    return {g[30:0], ~(g[31] ^ g[21] ^ g[1] ^ g[0])};
  endfunction

  function automatic logic [7:0] gen_pop();
    logic [7:0] b;
    b   = gen[7:0];
    gen = lfsr_next(gen);
    return b;
  endfunction

  function automatic int sat(input int c, input int m);
    return (c > m) ? m : c;
  endfunction

  task automatic model_reset();
    m_locked = 0;
    hq.delete();
    m_prev = '0;
    m_pred = '0;
    m_miss = 0;
    m_cnt  = 0;
    exp_err = 0;
  endtask

  task automatic model_update(input logic [7:0] d, input logic v, input logic c);
    logic [31:0] g;
    logic [7:0]  e;
    exp_err = 0;
    if (v) begin
      if (!m_locked) begin
        if (hq.size() > 0 && d[7:1] != m_prev[6:0]) hq.delete();
        hq.push_back(d[0]);
        m_prev = d;
        if (hq.size() == 32) begin
          g = '0;
          foreach (hq[i]) g = {g[30:0], hq[i]};
          hq.delete();
          if (g != 32'hFFFF_FFFF) begin
            m_locked = 1;
            m_pred   = g;
            m_miss   = 0;
          end
        end
      end else begin
        m_pred = lfsr_next(m_pred);
        e = m_pred[7:0];
        if (d != e) begin
          exp_err = 1;
          m_cnt++;
          m_miss++;
          if (m_miss == 4) begin
            m_locked = 0;
            m_miss = 0;
            hq.delete();
          end
        end else begin
          m_miss = 0;
        end
      end
    end
    if (c) m_cnt = 0;
  endtask

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic check_now(input string tag);
    cmp({tag, "/locked"},  32'(locked),     32'(m_locked));
    cmp({tag, "/err"},     32'(err),        32'(exp_err));
    cmp({tag, "/cnt"},     32'(err_count),  32'(sat(m_cnt, 65535)));
    cmp({tag, "/locked4"}, 32'(locked4),    32'(m_locked));
    cmp({tag, "/err4"},    32'(err4),       32'(exp_err));
    cmp({tag, "/cnt4"},    32'(err_count4), 32'(sat(m_cnt, 15)));
  endtask

  task automatic step(input string tag, input logic [7:0] d, input logic v, input logic c);
    @(negedge clk);
    check_now(tag);
    din = d;
    din_valid = v;
    clr_cnt = c;
    model_update(d, v, c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_now("pre_rst");
    rst_n = 1'b0;
    din_valid = 1'b0;
    clr_cnt = 1'b0;
    model_reset();
    @(negedge clk);
    check_now("rst");
    rst_n = 1'b1;
  endtask

  task automatic new_seed();
    gen = $urandom();
    if (gen == 32'hFFFF_FFFF) gen = 32'h1234_5678;
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] ns;
    rst_n = 1'b0;
    din = '0;
    din_valid = 1'b0;
    clr_cnt = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_now("reset");
    rst_n = 1'b1;

    // Clean stream from fixed seed: lock exactly on the 32nd sample
    gen = 32'h6B1C_CA14;
    for (int i = 0; i < 31; i++) step("hunt", gen_pop(), 1'b1, 1'b0);
    @(posedge clk); #1;
    cmp("no_lock_31", 32'(locked), 32'd0);
    step("hunt", gen_pop(), 1'b1, 1'b0);
    @(posedge clk); #1;
    cmp("lock_32", 32'(locked), 32'd1);
    for (int i = 0; i < 1000; i++) step("clean", gen_pop(), 1'b1, 1'b0);

    // Single corrupted sample
    step("one_bad", gen_pop() ^ 8'h01, 1'b1, 1'b0);
    @(posedge clk); #1;
    cmp("one_bad_err", 32'(err), 32'd1);
    for (int i = 0; i < 20; i++) step("after_one", gen_pop(), 1'b1, 1'b0);

    // Four consecutive errors drop lock, then relock after 32 clean samples
    for (int i = 0; i < 4; i++) step("four_bad", gen_pop() ^ 8'h01, 1'b1, 1'b0);
    @(posedge clk); #1;
    cmp("loss_locked", 32'(locked), 32'd0);
    cmp("loss_cnt", 32'(err_count), 32'd5);
    for (int i = 0; i < 31; i++) step("relock", gen_pop(), 1'b1, 1'b0);
    @(posedge clk); #1;
    cmp("relock_31", 32'(locked), 32'd0);
    step("relock", gen_pop(), 1'b1, 1'b0);
    @(posedge clk); #1;
    cmp("relock_32", 32'(locked), 32'd1);
    for (int i = 0; i < 10; i++) step("relocked", gen_pop(), 1'b1, 1'b0);

    // Random valid gaps on a clean stream
    do_reset();
    new_seed();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 1) step("gaps", gen_pop(), 1'b1, 1'b0);
      else step("gaps", 8'($urandom()), 1'b0, 1'b0);
    end

    // Continuity break at sample 20 restarts the fill
    do_reset();
    new_seed();
    for (int i = 0; i < 19; i++) begin
      b = gen_pop();
      step("pre_break", b, 1'b1, 1'b0);
    end
    do begin
      ns = $urandom();
    end while (ns[7:1] == b[6:0] || ns == 32'hFFFF_FFFF);
    gen = ns;
    for (int i = 0; i < 31; i++) step("post_break", gen_pop(), 1'b1, 1'b0);
    @(posedge clk); #1;
    cmp("break_no_lock_31", 32'(locked), 32'd0);
    step("post_break", gen_pop(), 1'b1, 1'b0);
    @(posedge clk); #1;
    cmp("break_lock_32", 32'(locked), 32'd1);

    // All-0xFF stream is the lock-up pattern and must never lock
    do_reset();
    for (int i = 0; i < 100; i++) step("all_ff", 8'hFF, 1'b1, 1'b0);
    @(posedge clk); #1;
    cmp("all_ff_unlocked", 32'(locked), 32'd0);

    // Saturation of the 4-bit counter, then clear racing a mismatch
    do_reset();
    new_seed();
    for (int i = 0; i < 34; i++) step("sat_lock", gen_pop(), 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step("sat_bad", gen_pop() ^ 8'h01, 1'b1, 1'b0);
      step("sat_good", gen_pop(), 1'b1, 1'b0);
    end
    @(posedge clk); #1;
    cmp("sat_cnt4", 32'(err_count4), 32'd15);
    cmp("sat_cnt16", 32'(err_count), 32'd20);
    step("clr_vs_err", gen_pop() ^ 8'h01, 1'b1, 1'b1);
    @(posedge clk); #1;
    cmp("clr_err", 32'(err), 32'd1);
    cmp("clr_cnt", 32'(err_count), 32'd0);
    for (int i = 0; i < 3; i++) step("after_clr", gen_pop(), 1'b1, 1'b0);
    step("pre_async", gen_pop() ^ 8'h01, 1'b1, 1'b0);
    step("pre_async", gen_pop(), 1'b1, 1'b0);

    // Asynchronous reset while locked with a nonzero count
    @(negedge clk);
    check_now("before_async");
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_locked", 32'(locked), 32'd0);
    cmp("async_cnt", 32'(err_count), 32'd0);
    cmp("async_cnt4", 32'(err_count4), 32'd0);
    din_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("post_async", gen_pop(), 1'b1, 1'b0);
    @(negedge clk);
    check_now("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
